// File: rtl/clkdiv_pkg.sv
// Shared definitions for the divided-clock measurement block: FSM state encoding
// and default parameter values.
package clkdiv_pkg;

    localparam int DEFAULT_W    = 16;
    localparam int DEFAULT_SYNC = 2;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MEAS = 1'b1
    } state_e;

endpackage

// File: rtl/clkdiv_meas_sync_edge.sv
// Reusable SYNC-stage synchronizer followed by one delay flop; produces single-cycle
// rise/fall pulses of the synchronized level.
module sync_edge #(
    parameter int SYNC = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_in,
    output logic rise,
    output logic fall
);

    logic [SYNC-1:0] sync_q;
    logic [SYNC-1:0] sync_d;
    logic            dly_q;
    logic            dly_d;

    // Next-state of the synchronizer chain and delay flop.
    always_comb begin
        sync_d = {sync_q[SYNC-2:0], d_in};
        dly_d  = sync_q[SYNC-1];
    end

    // Synchronizer and delay registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC{1'b0}};
            dly_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            dly_q  <= dly_d;
        end
    end

    assign rise = sync_q[SYNC-1] & ~dly_q;
    assign fall = ~sync_q[SYNC-1] & dly_q;

endmodule

// File: rtl/clkdiv_meas.sv
// Measures period and high time of a slow asynchronous input in clk cycles.
// Optional feature macro: CLKDIV_MEAS_STABLE_EN (stable = last two periods identical).
module clkdiv_meas
    import clkdiv_pkg::*;
#(
    parameter int W    = DEFAULT_W,
    parameter int SYNC = DEFAULT_SYNC
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in,
    output logic [W-1:0] period,
    output logic [W-1:0] high,
    output logic         valid,
    output logic         busy,
    output logic         timeout,
    output logic         stable
);

    localparam logic [W-1:0] CNT_MAX  = {W{1'b1}};
    localparam logic [W-1:0] CNT_ONE  = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};

    logic         rise_s;
    logic         fall_s;
    logic         stable_cmp_s;
    state_e       state_q,   state_d;
    logic [W-1:0] cnt_q,     cnt_d;
    logic [W-1:0] high_r_q,  high_r_d;
    logic [W-1:0] period_q,  period_d;
    logic [W-1:0] high_q,    high_d;
    logic         valid_q,   valid_d;
    logic         busy_q,    busy_d;
    logic         timeout_q, timeout_d;
    logic         stable_q,  stable_d;

    sync_edge #(.SYNC(SYNC)) u_sync_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .d_in  (in),
        .rise  (rise_s),
        .fall  (fall_s)
    );

`ifdef CLKDIV_MEAS_STABLE_EN
    logic have_prev_q, have_prev_d;

    // Tracks whether a period has been published since the last IDLE.
    always_comb begin
        if ((state_q == ST_MEAS) && rise_s) begin
            have_prev_d = 1'b1;
        end else if ((state_q == ST_MEAS) && (cnt_q == CNT_MAX)) begin
            have_prev_d = 1'b0;
        end else begin
            have_prev_d = have_prev_q;
        end
    end

    // Previous-publication flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            have_prev_q <= 1'b0;
        end else begin
            have_prev_q <= have_prev_d;
        end
    end

    assign stable_cmp_s = have_prev_q && (cnt_q == period_q) && (high_r_q == high_q);
`else
    assign stable_cmp_s = 1'b0;
`endif

    // Counter, FSM transitions and output next-state.
    always_comb begin
        state_d   = state_q;
        high_r_d  = high_r_q;
        period_d  = period_q;
        high_d    = high_q;
        valid_d   = 1'b0;
        timeout_d = timeout_q;
        stable_d  = stable_q;

        if (rise_s) begin
            cnt_d = CNT_ONE;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end

        case (state_q)
            ST_IDLE: begin
                if (rise_s) begin
                    state_d   = ST_MEAS;
                    timeout_d = 1'b0;
                    high_r_d  = CNT_ZERO;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_MEAS: begin
                // high_r is cleared on every rise so a missing fall publishes zero.
                if (rise_s) begin
                    period_d = cnt_q;
                    high_d   = high_r_q;
                    valid_d  = 1'b1;
                    high_r_d = CNT_ZERO;
                    stable_d = stable_cmp_s;
                end else if (cnt_q == CNT_MAX) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                    stable_d  = 1'b0;
                end else if (fall_s) begin
                    high_r_d = cnt_q;
                end else begin
                    high_r_d = high_r_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_MEAS);
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= CNT_ZERO;
            high_r_q  <= CNT_ZERO;
            period_q  <= CNT_ZERO;
            high_q    <= CNT_ZERO;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            stable_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            high_r_q  <= high_r_d;
            period_q  <= period_d;
            high_q    <= high_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            stable_q  <= stable_d;
        end
    end

    assign period  = period_q;
    assign high    = high_q;
    assign valid   = valid_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;
    assign stable  = stable_q;

endmodule
